// File: rtl/tinker_mem_pkg.sv
// Shared types for the tinker memory responder: access size, FSM states and
// the default storage size.
package tinker_mem_pkg;

  localparam int MEM_BYTES_DEFAULT = 524288;

  typedef enum logic {
    MEM_W32 = 1'b0,
    MEM_D64 = 1'b1
  } mem_size_t;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_RESP
  } mem_state_t;

  function automatic logic [63:0] size_bytes(input mem_size_t size);
    return (size == MEM_D64) ? 64'd8 : 64'd4;
  endfunction

endpackage

// File: rtl/tinker_byte_ram.sv
// Byte-addressed storage with an 8-lane byte-enable write port and a
// combinational 8-byte little-endian read port starting at addr_i.
module tinker_byte_ram #(
  parameter int MEM_BYTES = 524288,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        be_i,
  input  logic [63:0]       wdata_i,
  output logic [63:0]       rdata_o
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  logic [7:0]      mem_q [MEM_BYTES];
  logic [ADDR_W:0] idx [8];
  logic [7:0]      in_range;

  // Lanes that run past the end of storage read as zero and never write.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      idx[k]             = {1'b0, addr_i} + (ADDR_W + 1)'(k);
      in_range[k]        = idx[k] < LIMIT;
      rdata_o[8*k +: 8]  = in_range[k] ? mem_q[idx[k][ADDR_W-1:0]] : 8'h00;
    end
  end

  // NOTE: the storage array has no reset; its contents survive reset and a
  // reset loop over every byte would not map onto a RAM macro.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (be_i[k] && in_range[k]) begin
        mem_q[idx[k][ADDR_W-1:0]] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/tinker_mem_responder.sv
// Fixed-latency memory responder: one outstanding 32/64-bit little-endian
// access on valid/ready request and response channels.
module tinker_mem_responder
  import tinker_mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               ADDR_W    = $clog2(MEM_BYTES);
  localparam int               CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [63:0]      MEM_LIMIT = 64'(MEM_BYTES);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q;
  mem_size_t        size_q;
  logic [63:0]      addr_q, wdata_q;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             acc_write;
  mem_size_t        acc_size;
  logic [63:0]      acc_addr, acc_wdata;
  logic             acc_err, do_access;
  logic [7:0]       ram_be;
  logic [63:0]      ram_rdata;

  // With LATENCY==1 the access happens on the accept edge itself, so in IDLE
  // the live request fields feed the datapath instead of the holding registers.
  always_comb begin
    if (state_q == MS_IDLE) begin
      acc_write = req_write;
      acc_size  = mem_size_t'(req_size);
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_write = write_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_err = acc_addr > (MEM_LIMIT - size_bytes(acc_size));
    ram_be  = 8'h00;
    if (do_access && acc_write && !acc_err) begin
      ram_be = (acc_size == MEM_D64) ? 8'hFF : 8'h0F;
    end
  end

  tinker_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .addr_i  (acc_addr[ADDR_W-1:0]),
    .be_i    (ram_be),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_d   = MS_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = MS_WAIT;
          end
        end
      end
      MS_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          do_access = 1'b1;
          state_d   = MS_RESP;
        end
      end
      MS_RESP: begin
        if (rsp_ready) state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? 64'h0
              : (acc_size == MEM_D64) ? ram_rdata : {32'h0, ram_rdata[31:0]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= MEM_W32;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == MS_IDLE && req_valid) begin
        write_q <= req_write;
        size_q  <= mem_size_t'(req_size);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready = (state_q == MS_IDLE);
  assign rsp_valid = (state_q == MS_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Scoreboard bench for tinker_mem_responder: a byte-array reference model
// predicts each response at acceptance; a negedge monitor checks responses.
module tb_tinker_mem_responder;

  localparam int MEM_BYTES = 4096;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_size = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;

  tinker_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [MEM_BYTES];
  int         n_vec = 0, n_bad = 0;
  int         cyc = 0, last_acc = 0, rel_cyc = 0;
  int         a0, a1, a2;
  logic       prev_valid = 1'b0;
  logic       rand_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain byte array, bounds from address + length.
  function automatic exp_t model_access(input logic wr, input logic sz,
                                        input logic [63:0] addr, input logic [63:0] wd);
    exp_t        e;
    int          n = sz ? 8 : 4;
    logic [63:0] mb = 64'(MEM_BYTES);
    e.err     = (addr >= mb) || ((mb - addr) < 64'(n));
    e.rdata   = '0;
    e.acc_cyc = 0;
    if (!e.err) begin
      for (int i = 0; i < n; i++) begin
        if (wr) model[int'(addr) + i] = wd[8*i +: 8];
        else    e.rdata[8*i +: 8]     = model[int'(addr) + i];
      end
    end
    return e;
  endfunction

  task automatic issue(input logic wr, input logic sz, input logic [63:0] addr, input logic [63:0] wd);
    logic acc = 1'b0;
    int   waited = 0;
    exp_t e;
    req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = req_ready;
      if (acc) begin
        e         = model_access(wr, sz, addr, wd);
        e.acc_cyc = cyc;
        last_acc  = cyc;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (!acc && ++waited > 200) begin
        n_vec++; n_bad++;
        $display("FAIL accept_timeout: request addr %h never accepted", addr);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(posedge clk); waited++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid) begin
        check("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_rsp: rdata %h err %b with nothing outstanding", rsp_rdata, rsp_err);
        end else begin
          if (!prev_valid) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(LATENCY));
          check("rsp_rdata", rsp_rdata, sb[0].rdata);
          check("rsp_err", 64'(rsp_err), 64'(sb[0].err));
          if (rsp_ready) void'(sb.pop_front());
        end
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
    #2;
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Give every byte a known value.
    for (int a = 0; a < MEM_BYTES; a += 8) issue(1'b1, 1'b1, 64'(a), {$urandom, $urandom});

    // Directed little-endian and boundary accesses.
    issue(1'b1, 1'b1, 64'h108, 64'h0);
    issue(1'b1, 1'b1, 64'h100, 64'h1122334455667788);
    issue(1'b0, 1'b0, 64'h100, 64'h0);
    issue(1'b0, 1'b0, 64'h104, 64'h0);
    issue(1'b0, 1'b1, 64'h103, 64'h0);
    issue(1'b0, 1'b1, 64'hFF8, 64'h0);
    issue(1'b0, 1'b1, 64'hFFC, 64'h0);
    issue(1'b0, 1'b0, 64'hFFC, 64'h0);
    issue(1'b0, 1'b1, 64'hFF9, 64'h0);
    issue(1'b1, 1'b0, 64'hFFD, 64'hA5A5A5A5A5A5A5A5);
    issue(1'b0, 1'b1, 64'hFF8, 64'h0);
    issue(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    issue(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0123456789ABCDEF);
    issue(1'b0, 1'b0, 64'h0, 64'h0);
    drain();

    // Backpressure: response held while a new request waits.
    rsp_ready = 1'b0;
    issue(1'b0, 1'b1, 64'h100, 64'h0);
    fork
      issue(1'b0, 1'b0, 64'h104, 64'h0);
      begin
        repeat (LATENCY + 5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        rel_cyc = cyc;
      end
    join
    check("bp_accept_cycle", 64'(last_acc), 64'(rel_cyc + 1));
    drain();

    // Back-to-back with req_valid and rsp_ready held high.
    issue(1'b0, 1'b1, 64'h10, 64'h0); a0 = last_acc;
    issue(1'b1, 1'b0, 64'h20, 64'hCAFEF00D); a1 = last_acc;
    issue(1'b0, 1'b0, 64'h20, 64'h0); a2 = last_acc;
    check("b2b_gap1", 64'(a1 - a0), 64'(LATENCY + 1));
    check("b2b_gap2", 64'(a2 - a1), 64'(LATENCY + 1));
    drain();

    // Reset during WAIT drops a pending store.
    req_write = 1'b1; req_size = 1'b1; req_addr = 64'h200; req_wdata = 64'hDEAD; req_valid = 1'b1;
    @(negedge clk);
    check("rst_test_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midreset_req_ready", 64'(req_ready), 64'd1);
    check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midreset_rsp_rdata", rsp_rdata, 64'd0);
    check("midreset_rsp_err", 64'(rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue(1'b0, 1'b1, 64'h200, 64'h0);
    drain();

    // Randomised traffic with random response backpressure.
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      int          r;
      logic [63:0] addr;
      r = $urandom_range(0, 9);
      if (r == 0)      addr = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
      else if (r == 1) addr = 64'($urandom_range(MEM_BYTES - 12, MEM_BYTES + 4));
      else             addr = 64'($urandom_range(0, MEM_BYTES - 1));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, {$urandom, $urandom});
    end
    drain();
    rand_on = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
